assert_report_sched: RTL

//  Scheduler for concurrent-assertion result reporting. NUM_LANES property checkers raise

---
 rtl/assert_report_sched.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/assert_report_sched.sv
// Round-robin scheduler that buffers one pass/fail result per checker lane and
// serialises them onto a single valid/ready report channel. Optional statistics
// counters are compiled in with ASSERT_RPT_STATS_EN.
module assert_report_sched #(
  parameter  int NUM_LANES = 4,
  parameter  int CNT_W     = 16,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disable_i,
  input  logic [NUM_LANES-1:0] lane_pass,
  input  logic [NUM_LANES-1:0] lane_fail,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output logic [LANE_W-1:0]    rpt_lane,
  output logic                 rpt_fail,
  output logic [NUM_LANES-1:0] lane_ovf,
  input  logic                 ovf_clr,
`ifdef ASSERT_RPT_STATS_EN
  input  logic                 stats_clr,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
`endif
  output logic                 busy
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  if (NUM_LANES < 2 || CNT_W < 1) begin : g_param_check
    $error("assert_report_sched: NUM_LANES must be >= 2 and CNT_W >= 1");
  end

  logic [0:0]           state_q, state_d;
  logic [LANE_W-1:0]    ptr_q, ptr_d;
  logic                 rpt_valid_q, rpt_valid_d;
  logic [LANE_W-1:0]    rpt_lane_q, rpt_lane_d;
  logic                 rpt_fail_q, rpt_fail_d;
  logic [NUM_LANES-1:0] pv_q, pv_d;
  logic [NUM_LANES-1:0] pf_q, pf_d;
  logic [NUM_LANES-1:0] ovf_q, ovf_d;

  logic                 hs;
  logic                 load_en;
  logic                 sel_found;
  logic [LANE_W-1:0]    sel_idx;
  logic [LANE_W-1:0]    base_idx;
  logic [NUM_LANES-1:0] grant_vec;

  assign hs = rpt_valid_q & rpt_ready;

  // Search starts at the saved pointer when idle, or just past the lane being
  // retired when a handshake lets the next report load on the same edge.
  always_comb begin
    int base_i;
    int idx;
    base_i = 0;
    idx    = 0;
    if (state_q == ST_PRESENT) begin
      base_i = int'(rpt_lane_q) + 1;
      if (base_i >= NUM_LANES) base_i = 0;
    end else begin
      base_i = int'(ptr_q);
    end
    base_idx  = LANE_W'(base_i);
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = base_i + i;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (!sel_found && pv_q[LANE_W'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = LANE_W'(idx);
      end
    end
  end

  assign load_en = !disable_i && sel_found &&
                   ((state_q == ST_IDLE) || hs);

  // Per-lane capture: a lane being granted this edge may accept a new result
  // without overflow; otherwise a second result overflows, fail beating pass.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic evt;
      logic ovf_set;

      assign grant_vec[gi] = load_en && (sel_idx == LANE_W'(gi));
      assign evt           = !disable_i && (lane_pass[gi] || lane_fail[gi]);
      assign ovf_set       = evt && pv_q[gi] && !grant_vec[gi];

      always_comb begin
        pv_d[gi] = pv_q[gi];
        pf_d[gi] = pf_q[gi];
        if (disable_i) begin
          pv_d[gi] = 1'b0;
          pf_d[gi] = 1'b0;
        end else if (evt) begin
          pv_d[gi] = 1'b1;
          if (!pv_q[gi] || grant_vec[gi]) pf_d[gi] = lane_fail[gi];
          else                            pf_d[gi] = pf_q[gi] | lane_fail[gi];
        end else if (grant_vec[gi]) begin
          pv_d[gi] = 1'b0;
          pf_d[gi] = 1'b0;
        end
      end

      always_comb begin
        ovf_d[gi] = ovf_q[gi];
        if (ovf_clr) ovf_d[gi] = 1'b0;
        if (ovf_set) ovf_d[gi] = 1'b1;
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rpt_valid_d = rpt_valid_q;
    rpt_lane_d  = rpt_lane_q;
    rpt_fail_d  = rpt_fail_q;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          rpt_valid_d = 1'b1;
          rpt_lane_d  = sel_idx;
          rpt_fail_d  = pf_q[sel_idx];
          state_d     = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (hs) begin
          ptr_d = base_idx;
          if (load_en) begin
            rpt_lane_d = sel_idx;
            rpt_fail_d = pf_q[sel_idx];
          end else begin
            rpt_valid_d = 1'b0;
            rpt_lane_d  = '0;
            rpt_fail_d  = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rpt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rpt_valid_q <= 1'b0;
      rpt_lane_q  <= '0;
      rpt_fail_q  <= 1'b0;
      pv_q        <= '0;
      pf_q        <= '0;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_lane_q  <= rpt_lane_d;
      rpt_fail_q  <= rpt_fail_d;
      pv_q        <= pv_d;
      pf_q        <= pf_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_lane  = rpt_lane_q;
  assign rpt_fail  = rpt_fail_q;
  assign lane_ovf  = ovf_q;
  assign busy      = (|pv_q) | rpt_valid_q;

`ifdef ASSERT_RPT_STATS_EN
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  // Counters saturate rather than wrap; a clear beats a same-cycle increment.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (stats_clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else if (hs) begin
      if (rpt_fail_q) begin
        if (!(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end else begin
        if (!(&pass_cnt_q)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`endif

endmodule
